// File: rtl/c15xx_pkg.sv
// Shared types and helpers for the 1541/1571 head tracker and its save queue.
package c15xx_pkg;

  localparam int HT_FIELD_W = 8;

  typedef enum logic [1:0] {STEP_NONE, STEP_IN, STEP_OUT} step_dir_e;

  typedef struct packed {
    logic [HT_FIELD_W-1:0] ht;
    logic                  side;
  } save_entry_t;

  function automatic int ht_width(input int ht_max);
    return (ht_max < 1) ? 1 : $clog2(ht_max + 1);
  endfunction

  // Quadrature: one phase forward is inward, one back is outward, two is ambiguous.
  function automatic step_dir_e step_dir(input logic [1:0] cur, input logic [1:0] prev);
    logic [1:0] d;
    d = cur - prev;
    case (d)
      2'd1:    return STEP_IN;
      2'd3:    return STEP_OUT;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/c15xx_save_queue.sv
// Two-entry save request FIFO; ack pops the head, pushes into a full queue set a sticky overflow.
module c15xx_save_queue
  import c15xx_pkg::*;
(
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        push,
  input  save_entry_t push_entry,
  input  logic        pop,
  output logic        req,
  output save_entry_t head,
  output logic        ovf
);

  logic [1:0]  cnt;
  save_entry_t e0, e1;
  logic        pop_ok;

  assign pop_ok = pop && (cnt != 2'd0);
  assign req    = (cnt != 2'd0);
  assign head   = e0;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
      ovf <= 1'b0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else if (pop_ok && push) begin
      // Pop first, then the new entry lands behind whatever remains.
      if (cnt == 2'd1) begin
        e0 <= push_entry;
      end else begin
        e0 <= e1;
        e1 <= push_entry;
      end
    end else if (pop_ok) begin
      e0  <= e1;
      cnt <= cnt - 2'd1;
    end else if (push) begin
      if (cnt == 2'd2) begin
        ovf <= 1'b1;
      end else begin
        if (cnt == 2'd0) e0 <= push_entry;
        else             e1 <= push_entry;
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/c15xx_head_tracker.sv
// Head position, side and dirty-track tracking for 1541/1571, with queued track saves
// and write-protect sense including the disk-change glitch.
module c15xx_head_tracker
  import c15xx_pkg::*;
#(
  parameter int HT_MAX      = 83,
  parameter int HT_RESET    = 36,
  parameter int NUM_SIDES   = 1,
  parameter int CHG_TIMEOUT = 15000000,
  parameter int HT_W        = ht_width(HT_MAX)
) (
  input  logic            clk32,
  input  logic            reset_n,
  input  logic            mtr,
  input  logic [1:0]      stp,
  input  logic            side_sel,
  input  logic            buff_we,
  input  logic            disk_change,
  input  logic            disk_readonly,
  output logic [HT_W-1:0] half_track,
  output logic            side,
  output logic            tr00_sense_n,
  output logic            wps_n,
  output logic            dirty,
  output logic            save_req,
  output logic [HT_W-1:0] save_ht,
  output logic            save_side,
  input  logic            save_ack,
  output logic            save_ovf
);

  localparam int TO_W = (CHG_TIMEOUT < 1) ? 1 : $clog2(CHG_TIMEOUT + 1);

  logic [1:0]      stp_r;
  logic            mtr_r, dc_r, readonly;
  logic [TO_W-1:0] timeout;
  step_dir_e       dir;
  logic            side_ev, save_ev, dc_rise, push;
  save_entry_t     push_entry, head;

  assign dir     = mtr ? step_dir(stp, stp_r) : STEP_NONE;
  assign side_ev = (NUM_SIDES == 2) && mtr && (side_sel != side);
  // Clamped steps still count as save events.
  assign save_ev = (dir != STEP_NONE) || side_ev || (mtr_r && !mtr);
  assign dc_rise = disk_change && !dc_r;
  assign push    = save_ev && (dirty || buff_we) && !dc_rise;

  assign push_entry.ht   = HT_FIELD_W'(half_track);
  assign push_entry.side = side;
  assign save_ht         = HT_W'(head.ht);
  assign save_side       = head.side;
  assign tr00_sense_n    = |half_track;

  c15xx_save_queue u_queue (
    .clk32      (clk32),
    .reset_n    (reset_n),
    .flush      (dc_rise),
    .push       (push),
    .push_entry (push_entry),
    .pop        (save_ack),
    .req        (save_req),
    .head       (head),
    .ovf        (save_ovf)
  );

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      stp_r      <= 2'd0;
      mtr_r      <= 1'b0;
      dc_r       <= 1'b0;
      half_track <= HT_W'(HT_RESET);
      side       <= 1'b0;
      dirty      <= 1'b0;
      readonly   <= 1'b0;
      timeout    <= '0;
      wps_n      <= 1'b1;
    end else begin
      stp_r <= stp;
      mtr_r <= mtr;
      dc_r  <= disk_change;
      wps_n <= ~readonly ^ (timeout != '0);

      if (dir == STEP_IN && half_track != HT_W'(HT_MAX)) half_track <= half_track + 1'b1;
      if (dir == STEP_OUT && half_track != '0)           half_track <= half_track - 1'b1;
      if (side_ev) side <= side_sel;

      if (dc_rise) begin
        readonly <= disk_readonly;
        timeout  <= TO_W'(CHG_TIMEOUT);
        dirty    <= 1'b0;
      end else begin
        if (timeout != '0) timeout <= timeout - 1'b1;
        // A save event consumes any dirtiness, including a same-cycle write.
        if (save_ev)      dirty <= 1'b0;
        else if (buff_we) dirty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c15xx_head_tracker.sv
// Directed and randomized bench for c15xx_head_tracker against a queue-based reference model.
module tb_c15xx_head_tracker;

  localparam int CT    = 100;
  localparam int HTMAX = 83;

  logic       clk32 = 1'b0, reset_n = 1'b0;
  logic       mtr = 1'b0, side_sel = 1'b0, buff_we = 1'b0;
  logic       disk_change = 1'b0, disk_readonly = 1'b0, save_ack = 1'b0;
  logic [1:0] stp = 2'd0;
  logic [6:0] half_track, save_ht;
  logic       side, tr00_sense_n, wps_n, dirty, save_req, save_side, save_ovf;

  c15xx_head_tracker #(
    .HT_MAX(HTMAX), .HT_RESET(36), .NUM_SIDES(2), .CHG_TIMEOUT(CT)
  ) dut (
    .clk32(clk32), .reset_n(reset_n), .mtr(mtr), .stp(stp), .side_sel(side_sel),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .half_track(half_track), .side(side), .tr00_sense_n(tr00_sense_n), .wps_n(wps_n),
    .dirty(dirty), .save_req(save_req), .save_ht(save_ht), .save_side(save_side),
    .save_ack(save_ack), .save_ovf(save_ovf)
  );

  always #5 clk32 = ~clk32;

  typedef struct {int ht; bit side;} ent_t;
  ent_t   q[$];
  int     m_ht = 36;
  bit     m_side, m_dirty, m_ovf, m_ro;
  bit     m_wps = 1'b1;
  longint cyc = 0, chg_cyc = -1;
  bit [1:0] p_stp;
  bit     p_mtr, p_dc;
  int     checks = 0, errors = 0;

  // Reference: evaluated from the inputs about to be sampled at the next edge.
  task automatic model_edge();
    bit inwin, dc, ev, sev;
    int mv;
    bit [1:0] d;
    cyc++;
    inwin = (chg_cyc >= 0) && (cyc - chg_cyc <= CT);
    m_wps = m_ro ? inwin : !inwin;
    dc  = disk_change && !p_dc;
    d   = stp - p_stp;
    mv  = !mtr ? 0 : (d == 2'd1) ? 1 : (d == 2'd3) ? -1 : 0;
    sev = mtr && (side_sel != m_side);
    ev  = (mv != 0) || sev || (p_mtr && !mtr);
    if (dc) begin
      q.delete();
      m_dirty = 0;
      m_ro    = disk_readonly;
      chg_cyc = cyc;
    end else begin
      if (save_ack && q.size() > 0) void'(q.pop_front());
      if (ev) begin
        if (m_dirty || buff_we) begin
          if (q.size() < 2) q.push_back('{m_ht, m_side});
          else m_ovf = 1;
        end
        m_dirty = 0;
      end else if (buff_we) m_dirty = 1;
    end
    m_ht = m_ht + mv;
    if (m_ht > HTMAX) m_ht = HTMAX;
    if (m_ht < 0) m_ht = 0;
    if (sev) m_side = side_sel;
    p_stp = stp; p_mtr = mtr; p_dc = disk_change;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk32);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (half_track !== 7'd36 || side !== 1'b0 || dirty !== 1'b0 || save_req !== 1'b0 ||
        save_ht !== 7'd0 || save_side !== 1'b0 || save_ovf !== 1'b0 || wps_n !== 1'b1 ||
        tr00_sense_n !== 1'b1) begin
      errors++;
      $display("FAIL reset: ht=%0d side=%b dirty=%b req=%b sht=%0d sside=%b ovf=%b wps=%b tr00=%b want 36/0/0/0/0/0/0/1/1",
               half_track, side, dirty, save_req, save_ht, save_side, save_ovf, wps_n, tr00_sense_n);
    end
  endtask

  task automatic test_steps();
    mtr = 1'b1; tick();
    for (int i = 1; i <= 4; i++) begin
      stp = stp + 2'd1; tick();
      checks++;
      if (half_track !== 7'(36 + i)) begin
        errors++; $display("FAIL step_in[%0d]: got %0d want %0d", i, half_track, 36 + i);
      end
    end
    stp = stp + 2'd2; tick();
    checks++;
    if (half_track !== 7'd40) begin
      errors++; $display("FAIL step_by_two: got %0d want 40", half_track);
    end
  endtask

  task automatic test_clamp();
    repeat (90) begin stp = stp + 2'd1; tick(); end
    checks++;
    if (half_track !== 7'd83) begin errors++; $display("FAIL clamp_max: got %0d want 83", half_track); end
    repeat (83) begin stp = stp - 2'd1; tick(); end
    checks++;
    if (half_track !== 7'd0 || tr00_sense_n !== 1'b0) begin
      errors++; $display("FAIL reach_zero: ht=%0d tr00=%b want 0/0", half_track, tr00_sense_n);
    end
    repeat (5) begin stp = stp - 2'd1; tick(); end
    checks++;
    if (half_track !== 7'd0) begin errors++; $display("FAIL clamp_zero: got %0d want 0", half_track); end
    repeat (40) begin stp = stp + 2'd1; tick(); end
    checks++;
    if (half_track !== 7'd40 || tr00_sense_n !== 1'b1) begin
      errors++; $display("FAIL back_to_40: ht=%0d tr00=%b want 40/1", half_track, tr00_sense_n);
    end
  endtask

  task automatic test_save();
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    checks++;
    if (dirty !== 1'b1) begin errors++; $display("FAIL dirty_set: got %b want 1", dirty); end
    stp = stp + 2'd1; tick();
    checks++;
    if (save_req !== 1'b1 || save_ht !== 7'd40 || dirty !== 1'b0 || half_track !== 7'd41) begin
      errors++; $display("FAIL save_enqueue: req=%b sht=%0d dirty=%b ht=%0d want 1/40/0/41",
                         save_req, save_ht, dirty, half_track);
    end
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    checks++;
    if (save_req !== 1'b0) begin errors++; $display("FAIL save_ack: req=%b want 0", save_req); end
  endtask

  task automatic test_overflow();
    stp = stp - 2'd1; tick();
    for (int i = 0; i < 3; i++) begin
      buff_we = 1'b1; stp = stp + 2'd1; tick(); buff_we = 1'b0;
    end
    checks++;
    if (save_ovf !== 1'b1 || save_ht !== 7'd40 || save_req !== 1'b1 || half_track !== 7'd43) begin
      errors++; $display("FAIL overflow: ovf=%b sht=%0d req=%b ht=%0d want 1/40/1/43",
                         save_ovf, save_ht, save_req, half_track);
    end
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    checks++;
    if (save_req !== 1'b1 || save_ht !== 7'd41) begin
      errors++; $display("FAIL drain_1: req=%b sht=%0d want 1/41", save_req, save_ht);
    end
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    checks++;
    if (save_req !== 1'b0 || save_ovf !== 1'b1) begin
      errors++; $display("FAIL drain_2: req=%b ovf=%b want 0/1", save_req, save_ovf);
    end
  endtask

  task automatic test_side();
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    side_sel = 1'b1; tick();
    checks++;
    if (side !== 1'b1 || save_req !== 1'b1 || save_ht !== 7'd43 || save_side !== 1'b0) begin
      errors++; $display("FAIL side_save: side=%b req=%b sht=%0d sside=%b want 1/1/43/0",
                         side, save_req, save_ht, save_side);
    end
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    mtr = 1'b0; tick();
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    checks++;
    if (save_req !== 1'b1 || save_ht !== 7'd43 || save_side !== 1'b1 || dirty !== 1'b0) begin
      errors++; $display("FAIL motor_stop_save: req=%b sht=%0d sside=%b dirty=%b want 1/43/1/0",
                         save_req, save_ht, save_side, dirty);
    end
    save_ack = 1'b1; tick(); save_ack = 1'b0;
    mtr = 1'b1; tick();
  endtask

  task automatic test_disk_change();
    int zeros;
    buff_we = 1'b1; stp = stp + 2'd1; tick(); buff_we = 1'b0;
    buff_we = 1'b1; tick(); buff_we = 1'b0;
    checks++;
    if (save_req !== 1'b1 || dirty !== 1'b1) begin
      errors++; $display("FAIL chg_setup: req=%b dirty=%b want 1/1", save_req, dirty);
    end
    disk_readonly = 1'b0; disk_change = 1'b1; save_ack = 1'b1; buff_we = 1'b1;
    tick();
    save_ack = 1'b0; buff_we = 1'b0;
    checks++;
    if (save_req !== 1'b0 || dirty !== 1'b0 || wps_n !== 1'b1) begin
      errors++; $display("FAIL chg_flush: req=%b dirty=%b wps=%b want 0/0/1", save_req, dirty, wps_n);
    end
    zeros = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (wps_n === 1'b0) zeros++;
    end
    checks++;
    if (zeros != CT || wps_n !== 1'b1) begin
      errors++; $display("FAIL chg_glitch: low_cycles=%0d wps=%b want %0d/1", zeros, wps_n, CT);
    end
    disk_change = 1'b0; tick();
  endtask

  task automatic test_random();
    int e0;
    for (int n = 0; n < 3000; n++) begin
      mtr = ($urandom_range(7) != 0);
      case ($urandom_range(3))
        0: stp = stp + 2'd1;
        1: stp = stp - 2'd1;
        2: stp = stp + 2'd2;
        default: ;
      endcase
      if ($urandom_range(15) == 0) side_sel = ~side_sel;
      buff_we  = ($urandom_range(2) == 0);
      save_ack = ($urandom_range(3) == 0);
      if (!disk_change && $urandom_range(199) == 0) begin
        disk_change = 1'b1; disk_readonly = $urandom_range(1);
      end else if (disk_change && $urandom_range(4) == 0) disk_change = 1'b0;
      tick();
      e0 = errors;
      checks++;
      if (half_track !== 7'(m_ht) || side !== m_side || tr00_sense_n !== (m_ht != 0)) begin
        errors++; $display("FAIL rnd_pos[%0d]: ht=%0d side=%b tr00=%b want %0d/%b", n, half_track, side, tr00_sense_n, m_ht, m_side);
      end
      checks++;
      if (dirty !== m_dirty || save_req !== (q.size() != 0) || save_ovf !== m_ovf) begin
        errors++; $display("FAIL rnd_state[%0d]: dirty=%b req=%b ovf=%b want %b/%b/%b", n, dirty, save_req, save_ovf, m_dirty, q.size() != 0, m_ovf);
      end
      checks++;
      if (wps_n !== m_wps) begin
        errors++; $display("FAIL rnd_wps[%0d]: got %b want %b", n, wps_n, m_wps);
      end
      if (q.size() != 0) begin
        checks++;
        if (save_ht !== 7'(q[0].ht) || save_side !== q[0].side) begin
          errors++; $display("FAIL rnd_head[%0d]: sht=%0d sside=%b want %0d/%b", n, save_ht, save_side, q[0].ht, q[0].side);
        end
      end
      if (errors - e0 > 0 && errors > 20) break;
    end
    buff_we = 1'b0; save_ack = 1'b0; disk_change = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk32);
    #1 reset_n = 1'b1;
    test_reset();
    test_steps();
    test_clamp();
    test_save();
    test_overflow();
    test_side();
    test_disk_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c15xx_head_tracker.md
Name: c15xx_head_tracker

Overview:
- Parametrised head-position and track-save controller for the 1541/1571 drive family.
- Sits between the drive logic (stepper phases, motor, side select) and the track buffer / SD track loader.
- Tracks half-track and side, decodes stepper quadrature with clamping, and tracks buffer dirtiness.
- Issues save requests through a 2-entry req/ack queue; previously this was a fire-and-forget pulse.
- Generates wps_n, including the disk-change write-protect glitch, and tr00_sense_n.

Parameters:
- HT_MAX, 83: highest reachable half-track.
- HT_RESET, 36: half-track after reset.
- NUM_SIDES, 1: 1 (1541) or 2 (1571); with 1, side_sel is ignored and side is held at 0.
- CHG_TIMEOUT, 15000000: clk32 cycles of inverted write-protect after a disk change.
- HT_W, $clog2(HT_MAX+1): half-track width (derived).

Ports:
- clk32  in  1  drive clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- mtr  in  1  spindle motor on
- stp  in  2  stepper phase
- side_sel  in  1  requested head side
- buff_we  in  1  track buffer write strobe; marks the current track dirty
- disk_change  in  1  image changed; rising-edge sensitive
- disk_readonly  in  1  readonly flag of the new image, sampled on the disk_change rise
- half_track  out  HT_W  current half-track
- side  out  1  current side
- tr00_sense_n  out  1  0 only when half_track==0
- wps_n  out  1  write-protect sense, active low
- dirty  out  1  current track modified and not yet queued for save
- save_req  out  1  level; a save is pending
- save_ht  out  HT_W  half-track of the head queue entry
- save_side  out  1  side of the head queue entry
- save_ack  in  1  one-cycle pulse; pops the head queue entry
- save_ovf  out  1  sticky; a save was dropped because the queue was full

Behaviour:
- Reset (async assert, sync release) values: half_track=HT_RESET, side=0, dirty=0, save_req=0, save_ht=0, save_side=0, save_ovf=0, readonly=0, timeout=0, wps_n=1.
- Step decode:
  - stp_r registers stp every cycle.
  - When mtr=1: stp==stp_r+1 (mod 4) is an inward step (+1); stp==stp_r-1 (mod 4) is an outward step (-1); a difference of 2 or 0 is no move.
  - Clamp: +1 at HT_MAX and -1 at 0 leave half_track unchanged but still count as a step event.
  - half_track updates on the first clk32 edge at which the new stp is sampled (1-cycle latency).
  - With mtr=0, steps are ignored, but stp_r still tracks stp.
- Side change (NUM_SIDES=2, mtr=1, side_sel!=side): side<=side_sel; this is a save event.
- Motor stop: mtr_r=1 and mtr=0 is a save event.
- Save event:
  - If dirty=1 (including buff_we in the same cycle), enqueue {old half_track, old side} (the pre-move position) and clear dirty.
  - If dirty=0, no entry is enqueued.
  - buff_we in the same cycle as the event marks the old track, not the new one.
- Dirty: buff_we sets dirty, except in a cycle where it is consumed by a save event as above.
- Queue:
  - 2 entries; save_req = (count!=0); save_ht/save_side show the head entry.
  - save_ack with count=0 is ignored.
  - Enqueue and ack in the same cycle: the pop happens first; count is unchanged and the new entry moves up correctly.
  - Enqueue at count=2 without an ack: the entry is dropped, save_ovf<=1; it clears only on reset.
- Disk change (rising edge of a registered disk_change):
  - readonly<=disk_readonly; timeout<=CHG_TIMEOUT.
  - Queue flushed (count=0), dirty=0.
  - disk_change has priority over a buff_we, save event or save_ack in the same cycle.
- timeout decrements to 0; ch = (timeout!=0); wps_n = ~readonly ^ ch, registered.
- tr00_sense_n = |half_track, combinational from the register.

Decomposition:
- Shared package c15xx_pkg: HT_W function, a step-direction enum (STEP_NONE, STEP_IN, STEP_OUT), and a save_entry_t struct {ht, side}.
- One sub-module, c15xx_save_queue: the 2-entry req/ack FIFO with overflow flag and flush.
- Step decode, dirty tracking and the wps timer stay in the top module.

Test Plan:
- Reset, then mtr=1, stp 0->1->2->3->0: half_track 36->40, one cycle after each phase change; stp 0->2: no move.
- 90 inward steps: half_track saturates at 83; then 83 outward steps reach 0 and tr00_sense_n=0; further outward steps keep 0.
- buff_we, then a step from 40->41: save_req=1, save_ht=40, dirty=0; save_ack pulse -> save_req=0.
- Three dirty step events with no ack: queue holds 40 then 41, save_ovf=1; two acks drain the queue in order.
- NUM_SIDES=2: buff_we, side_sel 0->1 -> save_side=0, side=1; then mtr 1->0 while dirty -> second entry {ht, 1}.
- disk_change rise with disk_readonly=0 and CHG_TIMEOUT=100: wps_n=0 for 100 cycles then 1; a pending queue entry and dirty are flushed in the same cycle.
